// File: rtl/logic_op_pipe.sv
// WIDTH-bit registered bitwise logic unit (AND/OR/XOR/NAND) with a STAGES-deep
// elastic pipeline, valid/ready handshake and a wrapping completion counter.

module logic_op_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       op_o
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;

  // Payload only moves when real data arrives, so c/c_op hold their last value
  // when a bubble passes through.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    op_d   = op_q;
    if (ld_i) begin
      vld_d = vld_i;
      if (vld_i) begin
        data_d = data_i;
        op_d   = op_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      op_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      op_q   <= op_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign op_o   = op_q;
endmodule

module logic_op_pipe #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [1:0]       c_op,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            ld;
  logic [STAGES-1:0]            lv;
  logic [STAGES-1:0][WIDTH-1:0] dat_q;
  logic [STAGES-1:0][1:0]       op_q;
  logic [WIDTH-1:0]             res;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  always_comb begin
    res = '0;
    case (op)
      2'd0:    res = a & b;
      2'd1:    res = a | b;
      2'd2:    res = a ^ b;
      default: res = ~(a & b);
    endcase
  end

  // Ready ripples back from the output: a stage may load when empty or when
  // its occupant moves on this cycle, which fills bubbles behind a stall.
  always_comb begin
    ld = '0;
    lv = '0;
    lv[LAST] = v_q[LAST] && out_ready && !reset;
    ld[LAST] = !v_q[LAST] || lv[LAST];
    for (int i = STAGES - 2; i >= 0; i--) begin
      lv[i] = v_q[i] && ld[i+1];
      ld[i] = !v_q[i] || lv[i];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      logic_op_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .ld_i   (ld[0]),
        .vld_i  (in_valid),
        .data_i (res),
        .op_i   (op),
        .vld_o  (v_q[0]),
        .data_o (dat_q[0]),
        .op_o   (op_q[0])
      );
    end else begin : g_body
      logic_op_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .ld_i   (ld[i]),
        .vld_i  (v_q[i-1]),
        .data_i (dat_q[i-1]),
        .op_i   (op_q[i-1]),
        .vld_o  (v_q[i]),
        .data_o (dat_q[i]),
        .op_o   (op_q[i])
      );
    end
  end

  assign in_ready  = ld[0] && !reset;
  assign out_valid = v_q[LAST] && !reset;
  assign c         = dat_q[LAST];
  assign c_op      = op_q[LAST];

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_cnt = cnt_q;
endmodule

// File: tb/tb_logic_op_pipe.sv
// Bench for logic_op_pipe: a small 2-bit/2-stage/4-bit-counter unit and an
// 8-bit/4-stage unit, each with an in-order scoreboard on its output.

module tb_logic_op_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic iv0 = 1'b0, ir0, ov0, or0 = 1'b1;
  logic [1:0] a0 = '0, b0 = '0, op0 = '0, c0, cop0;
  logic [3:0] cnt0;

  logic iv1 = 1'b0, ir1, ov1, or1 = 1'b1;
  logic [7:0] a1 = '0, b1 = '0, c1;
  logic [1:0] op1 = '0, cop1;
  logic [15:0] cnt1;

  int vecs = 0, errs = 0;
  logic [3:0] q0[$];
  logic [9:0] q1[$];

  logic_op_pipe #(.WIDTH(2), .STAGES(2), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .op(op0), .out_valid(ov0), .out_ready(or0), .c(c0), .c_op(cop0), .done_cnt(cnt0));

  logic_op_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .op(op1), .out_valid(ov1), .out_ready(or1), .c(c1), .c_op(cop1), .done_cnt(cnt1));

  function automatic logic [7:0] model(logic [7:0] x, logic [7:0] y, logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Scoreboard: pop/compare on output handshake, push on accept.
  always @(negedge clk) begin : mon
    logic [3:0] e0;
    logic [9:0] e1;
    logic [7:0] r;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ov0 && or0) begin
        vecs++;
        if (q0.size() == 0) begin
          errs++; $display("FAIL sb0_extra: got op=%0d c=%b, want nothing", cop0, c0);
        end else begin
          e0 = q0.pop_front();
          if ({cop0, c0} !== e0) begin
            errs++; $display("FAIL sb0_data: got op=%0d c=%b, want op=%0d c=%b", cop0, c0, e0[3:2], e0[1:0]);
          end
        end
      end
      if (ov1 && or1) begin
        vecs++;
        if (q1.size() == 0) begin
          errs++; $display("FAIL sb1_extra: got op=%0d c=%h, want nothing", cop1, c1);
        end else begin
          e1 = q1.pop_front();
          if ({cop1, c1} !== e1) begin
            errs++; $display("FAIL sb1_data: got op=%0d c=%h, want op=%0d c=%h", cop1, c1, e1[9:8], e1[7:0]);
          end
        end
      end
      if (iv0 && ir0) begin
        r = model({6'b0, a0}, {6'b0, b0}, op0);
        q0.push_back({op0, r[1:0]});
      end
      if (iv1 && ir1) q1.push_back({op1, model(a1, b1, op1)});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; or0 = 1'b1; or1 = 1'b1;
    tick; tick;
    vecs++; if (ov0 !== 1'b0) begin errs++; $display("FAIL rst_ov0: got %b want 0", ov0); end
    vecs++; if (ir0 !== 1'b0) begin errs++; $display("FAIL rst_ir0: got %b want 0", ir0); end
    vecs++; if ({cop0, c0} !== 4'h0) begin errs++; $display("FAIL rst_c0: got %h want 0", {cop0, c0}); end
    vecs++; if (cnt0 !== 4'h0) begin errs++; $display("FAIL rst_cnt0: got %0d want 0", cnt0); end
    vecs++; if (ov1 !== 1'b0 || ir1 !== 1'b0) begin errs++; $display("FAIL rst_u1_hs: got ov=%b ir=%b want 0 0", ov1, ir1); end
    vecs++; if ({cop1, c1, cnt1} !== 26'h0) begin errs++; $display("FAIL rst_u1_regs: got %h want 0", {cop1, c1, cnt1}); end
    reset = 1'b0;
    #1;
    vecs++; if (ir0 !== 1'b1 || ir1 !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b%b want 11", ir0, ir1); end
  endtask

  task automatic test_single;
    do_reset;
    or0 = 1'b1; iv0 = 1'b1; a0 = 2'b11; b0 = 2'b01; op0 = 2'd0;
    tick;
    iv0 = 1'b0;
    vecs++; if (ov0 !== 1'b0) begin errs++; $display("FAIL single_early: got ov=%b want 0", ov0); end
    tick;
    vecs++; if (ov0 !== 1'b1 || c0 !== 2'b01 || cop0 !== 2'd0) begin
      errs++; $display("FAIL single_out: got ov=%b c=%b op=%0d want ov=1 c=01 op=0", ov0, c0, cop0); end
    tick;
    vecs++; if (ov0 !== 1'b0 || cnt0 !== 4'd1) begin
      errs++; $display("FAIL single_after: got ov=%b cnt=%0d want ov=0 cnt=1", ov0, cnt0); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] cseq [4];
    logic       exp_ov;
    cseq[0] = 2'b10; cseq[1] = 2'b11; cseq[2] = 2'b01; cseq[3] = 2'b01;
    do_reset;
    or0 = 1'b1; a0 = 2'b10; b0 = 2'b11;
    for (int n = 0; n < 8; n++) begin
      iv0 = (n < 4);
      op0 = 2'(n);
      tick;
      exp_ov = (n >= 1 && n <= 4);
      vecs++; if (ov0 !== exp_ov) begin errs++; $display("FAIL sweep_ov[%0d]: got %b want %b", n, ov0, exp_ov); end
      if (exp_ov) begin
        vecs++; if (c0 !== cseq[n-1] || cop0 !== 2'(n-1)) begin
          errs++; $display("FAIL sweep_c[%0d]: got c=%b op=%0d want c=%b op=%0d", n, c0, cop0, cseq[n-1], n-1); end
      end
    end
    vecs++; if (cnt0 !== 4'd4) begin errs++; $display("FAIL sweep_cnt: got %0d want 4", cnt0); end
  endtask

  task automatic test_backpressure;
    do_reset;
    or0 = 1'b0;
    iv0 = 1'b1; a0 = 2'b01; b0 = 2'b10; op0 = 2'd1;
    #1;
    vecs++; if (ir0 !== 1'b1) begin errs++; $display("FAIL bp_ready0: got %b want 1", ir0); end
    tick;
    a0 = 2'b11; b0 = 2'b11; op0 = 2'd2;
    #1;
    vecs++; if (ir0 !== 1'b1) begin errs++; $display("FAIL bp_ready1: got %b want 1", ir0); end
    tick;
    a0 = 2'b00; b0 = 2'b01; op0 = 2'd3;
    #1;
    vecs++; if (ir0 !== 1'b0) begin errs++; $display("FAIL bp_full: got %b want 0", ir0); end
    for (int k = 0; k < 3; k++) begin
      tick;
      vecs++; if (ir0 !== 1'b0 || ov0 !== 1'b1 || c0 !== 2'b11 || cop0 !== 2'd1) begin
        errs++; $display("FAIL bp_stall[%0d]: got ir=%b ov=%b c=%b op=%0d want 0 1 11 1", k, ir0, ov0, c0, cop0); end
    end
    or0 = 1'b1;
    #1;
    vecs++; if (ir0 !== 1'b1) begin errs++; $display("FAIL bp_release: got %b want 1", ir0); end
    tick;
    iv0 = 1'b0;
    repeat (4) tick;
    vecs++; if (cnt0 !== 4'd3 || ov0 !== 1'b0) begin errs++; $display("FAIL bp_drain: got cnt=%0d ov=%b want 3 0", cnt0, ov0); end
    vecs++; if (q0.size() != 0) begin errs++; $display("FAIL bp_lost: got %0d pending want 0", q0.size()); end
  endtask

  task automatic test_soak;
    int   sent = 0;
    int   cyc = 0;
    logic acc = 1'b0;
    do_reset;
    iv1 = 1'b0;
    while ((sent < 1000 || q1.size() != 0) && cyc < 20000) begin
      or1 = ($urandom_range(0, 9) < 6);
      if (!iv1 || acc) begin
        iv1 = (sent < 1000) && ($urandom_range(0, 9) < 7);
        a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom);
      end
      #1;
      acc = iv1 && ir1;
      if (acc) sent++;
      tick;
      cyc++;
    end
    iv1 = 1'b0;
    vecs++; if (cyc >= 20000) begin errs++; $display("FAIL soak_timeout: got %0d sent want 1000 drained", sent); end
    vecs++; if (cnt1 !== 16'd1000) begin errs++; $display("FAIL soak_cnt: got %0d want 1000", cnt1); end
  endtask

  task automatic test_reset_mid;
    or1 = 1'b0; iv1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'(k);
      tick;
    end
    iv1 = 1'b0; reset = 1'b1; or1 = 1'b1;
    #1;
    vecs++; if (ov1 !== 1'b0) begin errs++; $display("FAIL rmid_in_reset: got ov=%b want 0", ov1); end
    tick;
    reset = 1'b0;
    vecs++; if (ov1 !== 1'b0 || cnt1 !== 16'd0) begin errs++; $display("FAIL rmid_after: got ov=%b cnt=%0d want 0 0", ov1, cnt1); end
    for (int k = 0; k < 6; k++) begin
      tick;
      vecs++; if (ov1 !== 1'b0) begin errs++; $display("FAIL rmid_stale[%0d]: got ov=%b want 0", k, ov1); end
    end
    iv1 = 1'b1; a1 = 8'hF0; b1 = 8'h3C; op1 = 2'd2;
    tick;
    a1 = 8'hA5; b1 = 8'h0F; op1 = 2'd3;
    tick;
    iv1 = 1'b0;
    repeat (6) tick;
    vecs++; if (cnt1 !== 16'd2 || q1.size() != 0) begin errs++; $display("FAIL rmid_post: got cnt=%0d pending=%0d want 2 0", cnt1, q1.size()); end
  endtask

  task automatic test_wrap;
    int   sent = 0, k = 0, cyc = 0;
    logic acc, h;
    do_reset;
    or0 = 1'b1;
    while (k < 17 && cyc < 200) begin
      iv0 = (sent < 17);
      a0 = 2'($urandom); b0 = 2'($urandom); op0 = 2'($urandom);
      #1;
      acc = iv0 && ir0;
      h = ov0 && or0;
      tick;
      cyc++;
      if (acc) sent++;
      if (h) begin
        k++;
        if (k >= 15) begin
          vecs++; if (cnt0 !== 4'(k)) begin errs++; $display("FAIL wrap[%0d]: got %0d want %0d", k, cnt0, k % 16); end
        end
      end
    end
    iv0 = 1'b0;
    vecs++; if (cyc >= 200) begin errs++; $display("FAIL wrap_timeout: got %0d handshakes want 17", k); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_soak;
    test_reset_mid;
    test_wrap;
    repeat (2) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
